// File: rtl/aes_pkg.sv
// Shared AES constants, key/byte types and the key-schedule state encoding.
package aes_pkg;
   localparam int AES_NR    = 14;
   localparam int AES_NK    = 8;
   localparam int AES_NITER = 7;

   typedef logic [0:255] aes_key256_t;
   typedef logic [0:127] aes_rkey_t;
   typedef logic [0:7]   aes_byte_t;

   typedef enum logic {IDLE, EXPAND} ks_state_t;
endpackage

// File: rtl/Key_generation.sv
// One combinational AES-256 expansion step: eight new key words from the previous eight.
module Key_generation
   import aes_pkg::*;
(
   input  aes_key256_t kin,
   input  logic [3:0]  keyid,
   output aes_key256_t kout
);
   logic [0:31] rot_w7, sub_a, sub_b;
   logic [0:31] n0, n1, n2, n3, n4, n5, n6, n7;
   aes_byte_t   rcon;

   assign rot_w7 = {kin[232:255], kin[224:231]};

   aes_rcon u_rcon (.keyid_i(keyid), .rcon_o(rcon));

   // sub_a feeds word 0; sub_b substitutes word 3 of the new half and feeds word 4.
   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox_a (.in_i(rot_w7[8*b +: 8]), .out_o(sub_a[8*b +: 8]));
      aes_sbox u_sbox_b (.in_i(n3[8*b +: 8]),     .out_o(sub_b[8*b +: 8]));
   end

   assign n0 = kin[0:31]    ^ sub_a ^ {rcon, 24'h000000};
   assign n1 = kin[32:63]   ^ n0;
   assign n2 = kin[64:95]   ^ n1;
   assign n3 = kin[96:127]  ^ n2;
   assign n4 = kin[128:159] ^ sub_b;
   assign n5 = kin[160:191] ^ n4;
   assign n6 = kin[192:223] ^ n5;
   assign n7 = kin[224:255] ^ n6;

   assign kout = {n0, n1, n2, n3, n4, n5, n6, n7};
endmodule

// File: rtl/aes_rcon.sv
// AES round constant selected by key-expansion iteration number.
module aes_rcon
   import aes_pkg::*;
(
   input  logic [3:0] keyid_i,
   output aes_byte_t  rcon_o
);
   always_comb begin
      case (keyid_i)
         4'd1:    rcon_o = 8'h01;
         4'd2:    rcon_o = 8'h02;
         4'd3:    rcon_o = 8'h04;
         4'd4:    rcon_o = 8'h08;
         4'd5:    rcon_o = 8'h10;
         4'd6:    rcon_o = 8'h20;
         4'd7:    rcon_o = 8'h40;
         4'd8:    rcon_o = 8'h80;
         4'd9:    rcon_o = 8'h1b;
         4'd10:   rcon_o = 8'h36;
         default: rcon_o = 8'h00;
      endcase
   end
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in and one byte out, as a constant lookup table.
module aes_sbox
   import aes_pkg::*;
(
   input  aes_byte_t in_i,
   output aes_byte_t out_o
);
   // Entry n occupies bits [8n : 8n+7] of the table.
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_o = SBOX[{in_i, 3'b000} +: 8];
endmodule

// File: rtl/aes256_key_scheduler.sv
// Sequential AES-256 key schedule: one expansion step per cycle, fifteen round keys
// kept in a flat register file with a registered read port.
module aes256_key_scheduler
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int NITER = AES_NITER
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  aes_key256_t key_in,
   output logic        busy,
   output logic        done,
   output logic        keys_valid,
   input  logic [3:0]  rk_idx,
   output aes_rkey_t   rk_out
);
   localparam int HALF = AES_NK * 16;

   ks_state_t   state_q;
   logic [2:0]  iter_q;
   aes_key256_t work_q;
   aes_key256_t kout;
   aes_rkey_t   rk_q [0:NR];
   aes_rkey_t   rk_out_q;
   aes_rkey_t   rk_rd_d;
   logic        done_q;
   logic        kv_q;

   Key_generation u_keygen (
      .kin   (work_q),
      .keyid ({1'b0, iter_q}),
      .kout  (kout)
   );

   // Indices past the last round key read as zero.
   always_comb begin
      rk_rd_d = '0;
      if (rk_idx <= 4'(NR)) rk_rd_d = rk_q[rk_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         iter_q   <= '0;
         work_q   <= '0;
         done_q   <= 1'b0;
         kv_q     <= 1'b0;
         rk_out_q <= '0;
         for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      end else begin
         done_q   <= 1'b0;
         rk_out_q <= rk_rd_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  rk_q[0] <= key_in[0:HALF-1];
                  rk_q[1] <= key_in[HALF:2*HALF-1];
                  work_q  <= key_in;
                  iter_q  <= 3'd1;
                  kv_q    <= 1'b0;
                  state_q <= EXPAND;
               end
            end
            EXPAND: begin
               work_q                <= kout;
               rk_q[{iter_q, 1'b0}]  <= kout[0:HALF-1];
               // The last step yields only rk[NR]; its upper half has no slot.
               if (iter_q == 3'(NITER)) begin
                  done_q  <= 1'b1;
                  kv_q    <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  rk_q[{iter_q, 1'b1}] <= kout[HALF:2*HALF-1];
                  iter_q               <= iter_q + 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = (state_q == EXPAND);
   assign done       = done_q;
   assign keys_valid = kv_q;
   assign rk_out     = rk_out_q;
endmodule

// File: tb/tb_aes256_key_scheduler.sv
// Directed bench for the AES-256 key scheduler using FIPS-197 key vectors.
module tb_aes256_key_scheduler;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [0:255] key_in;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rk_idx;
   logic [0:127] rk_out;

   int errors = 0;
   int checks = 0;
   logic [0:127] exp_q[$];

   localparam logic [0:255] KEY_C3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:255] KEY_A3 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   localparam logic [0:127] C3_RK [0:14] = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'h101112131415161718191a1b1c1d1e1f,
      128'ha573c29fa176c498a97fce93a572c09c,
      128'h1651a8cd0244beda1a5da4c10640bade,
      128'hae87dff00ff11b68a68ed5fb03fc1567,
      128'h6de1f1486fa54f9275f8eb5373b8518d,
      128'hc656827fc9a799176f294cec6cd5598b,
      128'h3de23a75524775e727bf9eb45407cf39,
      128'h0bdc905fc27b0948ad5245a4c1871c2f,
      128'h45f5a66017b2d387300d4d33640a820a,
      128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
      128'hf01afafee7a82979d7a5644ab3afe640,
      128'h2541fe719bf500258813bbd55a721c0a,
      128'h4e5a6699a9f24fe07e572baacdf8cdea,
      128'h24fc79ccbf0979e9371ac23c6d68de36
   };

   localparam logic [0:127] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
   localparam logic [0:127] A3_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
   localparam logic [0:127] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
   localparam logic [0:127] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

   aes256_key_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .rk_idx     (rk_idx),
      .rk_out     (rk_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(input int limit, output int cyc);
      int i;
      i   = 0;
      cyc = -1;
      while (cyc < 0 && i < limit) begin
         @(negedge clk);
         i++;
         if (done === 1'b1) cyc = i;
      end
   endtask

   task automatic read_rk(input logic [3:0] idx, output logic [0:127] val);
      @(negedge clk);
      rk_idx = idx;
      @(negedge clk);
      val = rk_out;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [0:127] v;
      rst_n  = 1'b0;
      start  = 1'b0;
      key_in = '0;
      rk_idx = 4'd0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b expected 0", keys_valid); end
      checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h expected 0", rk_out); end
      rst_n = 1'b1;
      read_rk(4'd14, v);
      checks++; if (v !== 128'h0) begin errors++; $display("FAIL reset_rk14: got %h expected 0", v); end
   endtask

   task automatic test_c3_schedule();
      int cyc;
      @(negedge clk);
      start  = 1'b1;
      key_in = KEY_C3;
      @(negedge clk);
      start  = 1'b0;
      key_in = {8{$urandom}};
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c3_busy_after_e0: got %b expected 1", busy); end
      checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL c3_kv_after_e0: got %b expected 0", keys_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL c3_done_after_e0: got %b expected 0", done); end
      wait_done(20, cyc);
      checks++; if (cyc !== 7) begin errors++; $display("FAIL c3_latency: got %0d expected 7", cyc); end
      checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL c3_kv_at_done: got %b expected 1", keys_valid); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL c3_done_pulse: got %b expected 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c3_busy_after_e8: got %b expected 0", busy); end
      checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL c3_kv_after_e8: got %b expected 1", keys_valid); end
   endtask

   task automatic test_read_sweep();
      logic [0:127] exp;
      for (int k = 0; k <= 15; k++) begin
         @(negedge clk);
         if (k > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (rk_out !== exp) begin errors++; $display("FAIL sweep_idx%0d: got %h expected %h", k - 1, rk_out, exp); end
         end
         rk_idx = 4'(k);
         if (k == 15) exp_q.push_back(128'h0);
         else         exp_q.push_back(C3_RK[k]);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (rk_out !== exp) begin errors++; $display("FAIL sweep_idx15: got %h expected %h", rk_out, exp); end
   endtask

   task automatic test_a3_schedule();
      int cyc;
      logic [0:127] v;
      @(negedge clk);
      start  = 1'b1;
      key_in = KEY_A3;
      @(negedge clk);
      start  = 1'b0;
      key_in = {8{$urandom}};
      wait_done(20, cyc);
      checks++; if (cyc !== 7) begin errors++; $display("FAIL a3_latency: got %0d expected 7", cyc); end
      read_rk(4'd0, v);
      checks++; if (v !== A3_RK0) begin errors++; $display("FAIL a3_rk0: got %h expected %h", v, A3_RK0); end
      read_rk(4'd1, v);
      checks++; if (v !== A3_RK1) begin errors++; $display("FAIL a3_rk1: got %h expected %h", v, A3_RK1); end
      read_rk(4'd2, v);
      checks++; if (v !== A3_RK2) begin errors++; $display("FAIL a3_rk2: got %h expected %h", v, A3_RK2); end
      read_rk(4'd14, v);
      checks++; if (v !== A3_RK14) begin errors++; $display("FAIL a3_rk14: got %h expected %h", v, A3_RK14); end
      repeat (3) @(negedge clk);
      checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL a3_kv_hold: got %b expected 1", keys_valid); end
   endtask

   task automatic test_read_during_expand();
      int  i;
      int  cyc;
      int  kv_high;
      @(negedge clk);
      rk_idx = 4'd1;
      start  = 1'b1;
      key_in = KEY_C3;
      @(negedge clk);
      start = 1'b0;
      checks++; if (rk_out !== A3_RK1) begin errors++; $display("FAIL rde_same_edge_old: got %h expected %h", rk_out, A3_RK1); end
      checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL rde_kv_drop: got %b expected 0", keys_valid); end
      @(negedge clk);
      checks++; if (rk_out !== C3_RK[1]) begin errors++; $display("FAIL rde_rk1_at_e1: got %h expected %h", rk_out, C3_RK[1]); end
      i       = 1;
      cyc     = -1;
      kv_high = 0;
      while (cyc < 0 && i < 20) begin
         if (keys_valid !== 1'b0) kv_high++;
         @(negedge clk);
         i++;
         if (done === 1'b1) cyc = i;
      end
      checks++; if (kv_high !== 0) begin errors++; $display("FAIL rde_kv_low_during_expand: got %0d high cycles expected 0", kv_high); end
      checks++; if (cyc !== 7) begin errors++; $display("FAIL rde_latency: got %0d expected 7", cyc); end
   endtask

   task automatic test_back_to_back();
      int dones;
      int done_at;
      int busy_low;
      int cyc;
      logic [0:127] v;
      @(negedge clk);
      start  = 1'b1;
      key_in = KEY_A3;
      dones    = 0;
      done_at  = -1;
      busy_low = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i <= 7 && busy !== 1'b1) busy_low++;
         if (done === 1'b1) begin dones++; done_at = i; end
         if (i == 8) key_in = KEY_C3;
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", dones); end
      checks++; if (done_at !== 8) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 8", done_at); end
      checks++; if (busy_low !== 0) begin errors++; $display("FAIL b2b_busy_gaps: got %0d expected 0", busy_low); end
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
      checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL b2b_kv_fall: got %b expected 0", keys_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_low: got %b expected 0", done); end
      wait_done(20, cyc);
      checks++; if (cyc !== 7) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 7", cyc); end
      read_rk(4'd14, v);
      checks++; if (v !== C3_RK[14]) begin errors++; $display("FAIL b2b_rk14: got %h expected %h", v, C3_RK[14]); end
      read_rk(4'd0, v);
      checks++; if (v !== C3_RK[0]) begin errors++; $display("FAIL b2b_rk0: got %h expected %h", v, C3_RK[0]); end
   endtask

   task automatic test_async_reset();
      int cyc;
      logic [0:127] v;
      @(negedge clk);
      start  = 1'b1;
      key_in = KEY_C3;
      rk_idx = 4'd14;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", done); end
      checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL arst_kv: got %b expected 0", keys_valid); end
      checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL arst_rk_out: got %h expected 0", rk_out); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         read_rk(4'(k), v);
         checks++;
         if (v !== 128'h0) begin errors++; $display("FAIL arst_rk%0d_cleared: got %h expected 0", k, v); end
      end
      @(negedge clk);
      start  = 1'b1;
      key_in = KEY_C3;
      @(negedge clk);
      start = 1'b0;
      wait_done(20, cyc);
      checks++; if (cyc !== 7) begin errors++; $display("FAIL arst_restart_latency: got %0d expected 7", cyc); end
      read_rk(4'd14, v);
      checks++; if (v !== C3_RK[14]) begin errors++; $display("FAIL arst_restart_rk14: got %h expected %h", v, C3_RK[14]); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_c3_schedule();
      test_read_sweep();
      test_a3_schedule();
      test_read_during_expand();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/aes256_key_scheduler.md
# aes256_key_scheduler

Sequential AES-256 key schedule controller. It accepts a 256-bit cipher key and iterates the combinational 256-bit expansion step over seven cycles. The fifteen resulting 128-bit round keys are held in an internal register file. The block sits between key loading and the encryption round datapath, which reads round keys by index once `keys_valid` is high.

## Interface
Parameters:
- `NR`, 14: number of cipher rounds; storage holds `NR+1` round keys.
- `NITER`, 7: expansion iterations per key.

Ports (clock and reset first; big-endian bit numbering `[0:N-1]`, word 0 = bits `[0:31]`):
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request expansion of `key_in`; sampled only in IDLE.
- `key_in`, in, `[0:255]`: cipher key; sampled only on the accepting edge.
- `busy`, out, 1: high while expanding.
- `done`, out, 1: one-cycle pulse when the schedule is complete.
- `keys_valid`, out, 1: level; all fifteen round keys are valid for the last accepted key.
- `rk_idx`, in, `[3:0]`: round-key read index, 0..14.
- `rk_out`, out, `[0:127]`: registered round key for `rk_idx`.

## Operation
States:
- **IDLE**
  - `start` high → capture key.
    - `rk[0]` = `key_in[0:127]`, `rk[1]` = `key_in[128:255]`.
    - `work` = `key_in`.
    - `iter` = 1, `keys_valid` = 0.
    - Go to EXPAND.
- **EXPAND** (one iteration per cycle)
  - `kout` = expand(`work`, keyid = `iter`).
  - `work` ← `kout`.
  - `iter` 1..6: `rk[2*iter]` ← `kout[0:127]`, `rk[2*iter+1]` ← `kout[128:255]`.
  - `iter` = 7: only `rk[14]` ← `kout[0:127]`; the upper half is discarded. Then `done` ← 1, `keys_valid` ← 1, go to IDLE.
  - Otherwise `iter` ← `iter`+1.

Rules and boundary conditions:
- `busy` = (state == EXPAND).
- `iter` is 3 bits; it never wraps past 7.
- `start` in EXPAND is ignored; no queuing.
- `start` on the same cycle `done` is high is accepted, because the state is already IDLE. `keys_valid` drops on that acceptance edge.
- `rk_idx` 15 returns all zeros.
- Reads during EXPAND return current storage contents, a mix of old and new keys. Consumers gate on `keys_valid`.
- `key_in` changes after acceptance have no effect.
- `rst_n` low at any time, including mid-EXPAND, aborts immediately:
  - state IDLE, `iter` 0, `work` 0;
  - all `rk` 0;
  - `busy`, `done`, `keys_valid`, `rk_out` all 0.

## Timing
- Accepting edge E0: `rk[0..1]` written at E0; `busy` high after E0.
- Iterations 1..7 at edges E1..E7; `rk[2..13]` written at E1..E6, `rk[14]` at E7.
- `done` and `keys_valid` go high after E7; `done` falls after E8.
- Start-to-done latency: 7 cycles. Throughput: one key per 8 cycles with back-to-back `start`, since acceptance is possible again at E8.
- Read latency: `rk_out` reflects `rk[rk_idx]` one cycle after `rk_idx` is sampled.
- A write and a read of the same index on the same edge return the old value.
- The expansion step is purely combinational between `work` and the storage/`work` registers. The critical path is two S-box levels in series (the W0 path, then the W4 path).

## Structure
Shared package `aes_pkg`:
- constants `AES_NR = 14`, `AES_NK = 8`, `AES_NITER = 7`;
- typedefs `aes_key256_t` `[0:255]`, `aes_rkey_t` `[0:127]`, `aes_byte_t` `[0:7]`;
- state enum `ks_state_t` {IDLE, EXPAND}.

Sub-modules:
- One instance of the existing 256-bit expansion step, `Key_generation`, with `kin` = `work`, `keyid` = `{1'b0, iter}` and `kout` as above. It brings its own S-box and Rcon sub-modules.
- Storage is a flat register array inside this block; no separate memory module.

## Test plan
- Key 000102…1f (FIPS-197 C.3), `start` for 1 cycle → `done` after E7. Reads must match:
  - `rk[0]` = 000102030405060708090a0b0c0d0e0f;
  - `rk[2]` = a573c29fa176c498a97fce93a572c09c;
  - `rk[14]` = 24fc79ccbf0979e9371ac23c6d68de36.
- Key 603deb10…0914dff4 (FIPS-197 A.3) → `rk[14]` = fe4890d1e6188d0b046df344706c631e; `keys_valid` stays 1 until the next accepted `start`.
- `start` held high through E1..E7 → exactly one schedule, one `done` pulse. With `start` still high at E8, a second schedule begins and `keys_valid` falls after E8.
- `rst_n` pulsed low asynchronously at E4 → all outputs and `rk[0..14]` read 0. A following `start` with the C.3 key completes normally with the correct `rk[14]`.
- `rk_idx` = 15 → `rk_out` = 0. `rk_idx` swept 0..14 → each value appears one cycle after its index.
- Reads during EXPAND: `rk[1]` = 101112131415161718191a1b1c1d1e1f at E1, while `keys_valid` = 0 throughout.
